// File: rtl/vip_uart_rx_multi.sv
// Multi-channel UART receive monitor: per-channel synchroniser, frame FSM and
// character FIFO with valid/ready drain and sticky overflow.
module vip_uart_rx_multi #(
  parameter int NumChan   = 1,
  parameter int FifoDepth = 16,
  parameter int DivWidth  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DivWidth-1:0]       clk_div_i,
  input  logic [1:0]                data_bits_i,
  input  logic                      parity_en_i,
  input  logic                      parity_odd_i,
  input  logic                      stop2_i,
  input  logic                      clear_i,
  input  logic [NumChan-1:0]        rx_i,
  output logic [NumChan-1:0]        chr_valid_o,
  input  logic [NumChan-1:0]        chr_ready_i,
  output logic [NumChan-1:0][7:0]   chr_data_o,
  output logic [NumChan-1:0]        chr_perr_o,
  output logic [NumChan-1:0]        chr_ferr_o,
  output logic [NumChan-1:0]        overflow_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int PtrX = PtrW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_e;

  function automatic logic parity_err(input logic acc, input logic pbit, input logic odd);
    return (acc ^ pbit) != odd;
  endfunction

  logic [DivWidth-1:0] div_eff_s;

  // Divisor clamp: fewer than two cycles per bit cannot place a mid-bit sample.
  always_comb begin
    if (clk_div_i < DivWidth'(2)) begin
      div_eff_s = DivWidth'(2);
    end else begin
      div_eff_s = clk_div_i;
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_ch
    logic                sync1_q, sync2_q;
    state_e              state_q;
    logic [DivWidth-1:0] cnt_q, div_q;
    logic [1:0]          nbits_q;
    logic                par_en_q, par_odd_q, stop2_q, stop_n_q;
    logic [2:0]          idx_q;
    logic [7:0]          shift_q;
    logic                par_q, perr_q, ferr_q;
    logic                rxs;

    logic [PtrW:0]       wptr_q, rptr_q;
    logic [9:0]          mem_q [FifoDepth];
    logic                ovf_q;
    logic                empty_s, full_s, push_s, pop_s, wr_s;
    logic [9:0]          push_data_s, head_s;

    assign rxs = sync2_q;

    // Two-flop synchroniser, idle-high after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= rx_i[c];
        sync2_q <= sync1_q;
      end
    end

    // Frame FSM; config is frozen at start-bit detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        div_q     <= DivWidth'(2);
        nbits_q   <= 2'd0;
        par_en_q  <= 1'b0;
        par_odd_q <= 1'b0;
        stop2_q   <= 1'b0;
        stop_n_q  <= 1'b0;
        idx_q     <= 3'd0;
        shift_q   <= 8'd0;
        par_q     <= 1'b0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!rxs) begin
              div_q     <= div_eff_s;
              nbits_q   <= data_bits_i;
              par_en_q  <= parity_en_i;
              par_odd_q <= parity_odd_i;
              stop2_q   <= stop2_i;
              cnt_q     <= (div_eff_s >> 1) - DivWidth'(1);
              idx_q     <= 3'd0;
              shift_q   <= 8'd0;
              par_q     <= 1'b0;
              perr_q    <= 1'b0;
              ferr_q    <= 1'b0;
              stop_n_q  <= 1'b0;
              state_q   <= START;
            end
          end
          START: begin
            if (cnt_q == '0) begin
              if (!rxs) begin
                cnt_q   <= div_q - DivWidth'(1);
                idx_q   <= 3'd0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - DivWidth'(1);
            end
          end
          DATA: begin
            if (cnt_q == '0) begin
              shift_q[idx_q] <= rxs;
              par_q          <= par_q ^ rxs;
              cnt_q          <= div_q - DivWidth'(1);
              if (idx_q == 3'd4 + {1'b0, nbits_q}) begin
                state_q <= par_en_q ? PARITY : STOP;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q - DivWidth'(1);
            end
          end
          PARITY: begin
            if (cnt_q == '0) begin
              perr_q  <= parity_err(par_q, rxs, par_odd_q);
              cnt_q   <= div_q - DivWidth'(1);
              state_q <= STOP;
            end else begin
              cnt_q <= cnt_q - DivWidth'(1);
            end
          end
          STOP: begin
            if (cnt_q == '0) begin
              ferr_q <= ferr_q | ~rxs;
              if (stop2_q && !stop_n_q) begin
                stop_n_q <= 1'b1;
                cnt_q    <= div_q - DivWidth'(1);
              end else begin
                // A low final stop means the line may be held in break.
                state_q <= rxs ? IDLE : BRK;
              end
            end else begin
              cnt_q <= cnt_q - DivWidth'(1);
            end
          end
          BRK: begin
            if (rxs) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign push_s      = (state_q == STOP) && (cnt_q == '0) && (!stop2_q || stop_n_q);
    assign push_data_s = {ferr_q | ~rxs, perr_q, shift_q};
    assign empty_s     = (wptr_q == rptr_q);
    assign full_s      = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                         (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign pop_s       = !empty_s && chr_ready_i[c];
    assign wr_s        = push_s && (!full_s || pop_s);
    assign head_s      = mem_q[rptr_q[PtrW-1:0]];

    // FIFO pointers and sticky overflow; a coinciding drop wins over clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (wr_s) begin
          wptr_q <= wptr_q + PtrX'(1);
        end
        if (pop_s) begin
          rptr_q <= rptr_q + PtrX'(1);
        end
        if (push_s && full_s && !pop_s) begin
          ovf_q <= 1'b1;
        end else if (clear_i) begin
          ovf_q <= 1'b0;
        end
      end
    end

    // Storage array; contents are only visible while the entry is valid.
    always_ff @(posedge clk_i) begin
      if (wr_s) begin
        mem_q[wptr_q[PtrW-1:0]] <= push_data_s;
      end
    end

    assign chr_valid_o[c] = !empty_s;
    assign chr_data_o[c]  = empty_s ? 8'd0 : head_s[7:0];
    assign chr_perr_o[c]  = empty_s ? 1'b0 : head_s[8];
    assign chr_ferr_o[c]  = empty_s ? 1'b0 : head_s[9];
    assign overflow_o[c]  = ovf_q;
  end

endmodule

// File: doc/vip_uart_rx_multi.md
Name: vip_uart_rx_multi

Overview:
- Multi-channel UART receive monitor for the SoC simulation fixture. It replaces ad-hoc single-line UART sniffing on the DUT `uart_tx` pins.
- Each channel deserialises one serial line using a runtime-configurable divisor and frame format. Characters and error flags are buffered in a per-channel FIFO and drained over valid/ready.
- Synthesisable, so it can also be instantiated in FPGA fixtures.

Parameters:
- NumChan, 1, number of independent serial lines monitored.
- FifoDepth, 16, entries per channel FIFO; power of two, >= 2.
- DivWidth, 16, width of the clock-cycles-per-bit divisor.

Ports:
- clk_i  in  1  fixture clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clk_div_i  in  DivWidth  clock cycles per bit, shared by all channels.
- data_bits_i  in  2  data bits per frame minus 5 (0 → 5 bits … 3 → 8 bits).
- parity_en_i  in  1  parity bit present.
- parity_odd_i  in  1  1 = odd parity, 0 = even.
- stop2_i  in  1  two stop bits.
- clear_i  in  1  clears sticky overflow flags (1-cycle pulse).
- rx_i  in  NumChan  serial lines, idle high, asynchronous to clk_i.
- chr_valid_o  out  NumChan  per-channel FIFO non-empty.
- chr_ready_i  in  NumChan  per-channel pop.
- chr_data_o  out  NumChan x 8  head character, zero-extended above the configured data bits.
- chr_perr_o  out  NumChan  head entry had a parity error.
- chr_ferr_o  out  NumChan  head entry had a framing error (stop bit sampled 0).
- overflow_o  out  NumChan  sticky: a character was dropped because the FIFO was full.

Behaviour:
- Reset (async on rst_i high):
  - all channel FSMs go to IDLE; FIFOs are emptied.
  - chr_valid_o = 0, chr_data_o = 0, chr_perr_o = 0, chr_ferr_o = 0, overflow_o = 0.
  - synchroniser flops are set to 1 (line idle).
  - reset mid-frame discards the partial character; no entry is produced.
- Input synchronisation: rx_i passes through 2 flops per channel; all timing below refers to the synchronised signal rxs.
- Effective divisor: div = max(clk_div_i, 2).
- Frame configuration:
  - data_bits, parity_en, parity_odd, stop2 and div are latched per channel at start-bit detection.
  - changes mid-frame do not affect the frame in progress.
- Per-channel FSM:
  - IDLE: when rxs is 0 → latch config, load counter with div/2 − 1 (integer division), go to START.
  - START: at counter == 0:
    - rxs = 0 → load div − 1, bit index = 0, go to DATA.
    - rxs = 1 → false start, return to IDLE; no entry is produced.
  - DATA: at counter == 0:
    - sample rxs into shift position bit index (LSB first); accumulate running parity.
    - on the last data bit → go to PARITY if parity_en, else STOP. Otherwise reload div − 1.
  - PARITY: sample the bit. perr = (XOR of data bits ^ parity bit) != parity_odd. Go to STOP.
  - STOP: sample at counter == 0. Any sampled stop bit = 0 sets ferr.
    - with stop2: sample first stop, reload, sample second; ferr if either is 0.
    - after the final stop sample, push {ferr, perr, data} into the FIFO in that same cycle.
    - next state: IDLE if rxs = 1; BREAK if ferr and rxs = 0.
  - BREAK: wait until rxs = 1, then go to IDLE. This prevents a held-low line from generating repeated characters.
- Counter: decrements by 1 every cycle in non-IDLE states.
  - Sample points fall at half-bit + k·div cycles after the detected falling edge.
  - An odd div truncates the half-bit.
- FIFO:
  - The push happens in the final-stop sample cycle. chr_valid_o rises in the next cycle.
  - Pop happens when chr_valid_o & chr_ready_i.
  - Push when full:
    - with a pop in the same cycle → the push is accepted, occupancy is unchanged.
    - without a pop → the character is dropped and overflow_o is set.
  - overflow_o stays set until clear_i; if clear_i and a new drop coincide, the flag stays set.
  - chr_ready_i while empty is ignored.
  - Read/write pointers wrap modulo FifoDepth; full and empty are distinguished by an extra pointer bit.
- Channels are fully independent. Only clear_i and the configuration inputs are shared.

Test Plan:
- 8N1, clk_div_i = 16, send 0x55 then 0xA3 on ch0 → two entries 0x55, 0xA3, perr = 0, ferr = 0; valid 1 cycle after the final stop sample; ch1 stays empty.
- 7E1, clk_div_i = 10, send 0x41 with a correct even parity bit, then 0x41 with the parity bit inverted → entry 1 has perr = 0, entry 2 has perr = 1; both have data 0x41.
- 8N2, drive the second stop bit low for 0x3C, then hold the line low for 5 bit times → one entry 0x3C with ferr = 1; FSM holds in BREAK; no further entries until the line returns high and a new frame is sent.
- Glitch: 3-cycle low pulse with clk_div_i = 16 → no entry (false start at the half-bit sample).
- FifoDepth = 4, send 6 chars with chr_ready_i = 0 → 4 entries retained (first four), overflow_o = 1; pulse clear_i → overflow_o = 0; then send with ready held high → no overflow.
- Assert rst_i during the DATA phase of a frame → outputs 0 immediately (asynchronously); after release, the next full frame 0x7E is received correctly.
